if_stage: RTL and testbench

- Instruction-fetch stage for the upcoming 5-stage pipelined LoongArch core. It sits directly upstream of the decode (ID) stage.
- It owns the PC, a pre-IF next-PC mux, the instruction SRAM request, and a one-entry instruction buffer.
- It hands {inst, pc} to ID over a valid/allowin handshake and accepts branch redirects from ID.
- The instruction SRAM is synchronous: address is presented in cycle N and data returns in cycle N+1.

---
 rtl/if_stage.sv | 97 +++++++++
 tb/tb_if_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage of the 5-stage LoongArch pipeline.
//   Owns the PC, the pre-IF next-PC mux, the instruction SRAM request and a
//   one-entry instruction buffer. It hands {inst, pc} to ID over a
//   valid/allowin handshake and takes branch redirects back from ID.
//
// Ports:
//   clk, resetn         clock; asynchronous active-low reset
//   ds_allowin          ID can accept an instruction this cycle
//   br_bus              {br_taken, br_target} from ID
//   fs_to_ds_valid      IF presents a valid instruction to ID
//   fs_to_ds_bus        {inst, pc}
//   inst_sram_en/we/addr/wdata  SRAM request (read-only: we/wdata tied to 0)
//   inst_sram_rdata     SRAM data, returned the cycle after the request
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          FS_TO_DS_BUS_WD = 64,
    parameter int          BR_BUS_WD       = 33
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;
    logic        to_fs_valid;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] inst_buf;
    logic        inst_buf_valid;
    logic [31:0] fs_inst;
    logic        ds_xfer;

    assign br_taken  = br_bus[BR_BUS_WD-1];
    assign br_target = br_bus[31:0];

    // Pre-IF: the request for the next instruction goes out while IF still
    // holds the current one, so nextpc is the SRAM address directly.
    assign to_fs_valid = resetn;
    assign seq_pc      = fs_pc + 32'd4;
    assign nextpc      = br_taken ? br_target : seq_pc;

    // A taken branch always opens IF: the held instruction is wrong-path.
    assign fs_ready_go    = 1'b1;
    assign fs_allowin     = !fs_valid || (fs_ready_go && ds_allowin) || br_taken;
    assign fs_to_ds_valid = fs_valid && fs_ready_go && !br_taken;
    assign ds_xfer        = fs_to_ds_valid && ds_allowin;

    assign inst_sram_en    = to_fs_valid && fs_allowin;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_wdata = 32'b0;

    // Once the stall has started the SRAM output is no longer trustworthy,
    // so the buffered copy takes precedence.
    assign fs_inst      = inst_buf_valid ? inst_buf : inst_sram_rdata;
    assign fs_to_ds_bus = {fs_inst, fs_pc};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_pc    <= RESET_PC - 32'd4;
            fs_valid <= 1'b0;
        end else if (to_fs_valid && fs_allowin) begin
            fs_pc    <= nextpc;
            fs_valid <= 1'b1;
        end
    end

    // Capture happens in the first stall cycle, which is exactly the cycle
    // the data for fs_pc is on the SRAM output. Release wins over capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_buf       <= 32'b0;
            inst_buf_valid <= 1'b0;
        end else if (ds_xfer || br_taken) begin
            inst_buf_valid <= 1'b0;
        end else if (fs_valid && !ds_allowin && !inst_buf_valid) begin
            inst_buf       <= inst_sram_rdata;
            inst_buf_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ds_allowin = 1'b0;
    logic [32:0] br_bus = '0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = '0;

    int checks = 0;
    int failures = 0;

    // Reference view of IF: which PC it holds, and whether it holds one.
    logic        m_v;
    logic [31:0] m_pc;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin), .br_bus(br_bus),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hdeadbeef;
    endfunction

    // Synchronous SRAM; output is garbage the cycle after an idle cycle.
    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? inst_of(inst_sram_addr) : $urandom;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive this cycle's inputs, then check outputs
    // against the reference view.
    task automatic drive_chk(input logic allow, input logic br, input logic [31:0] tgt);
        ds_allowin = allow;
        br_bus     = {br, tgt};
        #1;
        chk("we", {60'b0, inst_sram_we}, 64'h0);
        chk("wdata", {32'b0, inst_sram_wdata}, 64'h0);
        chk("en", {63'b0, inst_sram_en}, {63'b0, (!m_v || allow || br)});
        chk("addr", {32'b0, inst_sram_addr}, {32'b0, (br ? tgt : m_pc + 32'd4)});
        chk("valid", {63'b0, fs_to_ds_valid}, {63'b0, (m_v && !br)});
        if (m_v && !br) chk("bus", fs_to_ds_bus, {inst_of(m_pc), m_pc});
    endtask

    // Advance through the posedge to the next negedge, stepping the model.
    task automatic adv();
        logic allow, br;
        logic [31:0] tgt;
        allow = ds_allowin;
        br    = br_bus[32];
        tgt   = br_bus[31:0];
        @(posedge clk);
        if (br) begin
            m_pc = tgt; m_v = 1'b1;
        end else if (!m_v || allow) begin
            m_pc = m_pc + 32'd4; m_v = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic step(input logic allow, input logic br, input logic [31:0] tgt);
        drive_chk(allow, br, tgt);
        adv();
    endtask

    initial begin
        m_v  = 1'b0;
        m_pc = RESET_PC - 32'd4;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", {63'b0, fs_to_ds_valid}, 64'h0);
        chk("rst_en", {63'b0, inst_sram_en}, 64'h0);
        chk("rst_we", {60'b0, inst_sram_we}, 64'h0);
        chk("rst_wdata", {32'b0, inst_sram_wdata}, 64'h0);
        @(negedge clk);

        // Reset release and back-to-back fetch.
        resetn = 1'b1;
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("first_addr", {32'b0, inst_sram_addr}, {32'b0, RESET_PC});
        chk("first_en", {63'b0, inst_sram_en}, 64'h1);
        adv();
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("pc0", {32'b0, fs_to_ds_bus[31:0]}, 64'h1c000000);
        adv();
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("pc1", {32'b0, fs_to_ds_bus[31:0]}, 64'h1c000004);
        adv();

        // Stall on 0x1c000008; SRAM output is corrupted while idle.
        for (int i = 0; i < 3; i++) begin
            drive_chk(1'b0, 1'b0, 32'h0);
            chk("stall_en", {63'b0, inst_sram_en}, 64'h0);
            chk("stall_bus", fs_to_ds_bus, {inst_of(32'h1c000008), 32'h1c000008});
            adv();
        end
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("stall_rel", fs_to_ds_bus, {inst_of(32'h1c000008), 32'h1c000008});
        adv();
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("pc_c", {32'b0, fs_to_ds_bus[31:0]}, 64'h1c00000c);
        adv();

        // Taken branch while IF holds 0x1c000010.
        drive_chk(1'b1, 1'b1, 32'h1c000100);
        chk("br_valid", {63'b0, fs_to_ds_valid}, 64'h0);
        chk("br_addr", {32'b0, inst_sram_addr}, 64'h1c000100);
        adv();
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("br_pc", {32'b0, fs_to_ds_bus[31:0]}, 64'h1c000100);
        chk("br_dvalid", {63'b0, fs_to_ds_valid}, 64'h1);
        adv();

        // Branch during a stall with the buffer full.
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        drive_chk(1'b0, 1'b1, 32'h1c000200);
        chk("bst_en", {63'b0, inst_sram_en}, 64'h1);
        adv();
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("bst_bus", fs_to_ds_bus, {inst_of(32'h1c000200), 32'h1c000200});
        adv();

        // PC wrap.
        step(1'b1, 1'b1, 32'hfffffffc);
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("wrap_addr", {32'b0, inst_sram_addr}, 64'h0);
        adv();
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("wrap_pc", {32'b0, fs_to_ds_bus[31:0]}, 64'h0);
        adv();

        // Asynchronous reset between edges.
        step(1'b0, 1'b0, 32'h0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", {63'b0, fs_to_ds_valid}, 64'h0);
        chk("arst_en", {63'b0, inst_sram_en}, 64'h0);
        chk("arst_fsv", {63'b0, dut.fs_valid}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        m_v = 1'b0;
        m_pc = RESET_PC - 32'd4;
        resetn = 1'b1;
        drive_chk(1'b1, 1'b0, 32'h0);
        chk("rst2_addr", {32'b0, inst_sram_addr}, {32'b0, RESET_PC});
        adv();

        // Randomized traffic; ID only redirects on a held instruction.
        for (int i = 0; i < 1500; i++) begin
            logic allow, br;
            logic [31:0] tgt;
            allow = ($urandom_range(0, 9) < 7);
            br    = m_v && ($urandom_range(0, 99) < 15);
            case ($urandom_range(0, 9))
                0:       tgt = 32'hfffffffc;
                1:       tgt = $urandom;
                default: tgt = $urandom & 32'hfffffffc;
            endcase
            step(allow, br, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
